// File: rtl/sm_arith_pkg.sv
// rtl/sm_arith_pkg.sv - shared sign-magnitude constants and helpers
//
// Purpose: word width, magnitude limit and field helpers for the
// sign-magnitude arithmetic blocks (adder, subtractor, convolution core).
// Format: bit [SM_W-1] is the sign (1 = negative), bits [SM_W-2:0] are the
// magnitude.
// Ports: none (package).

package sm_arith_pkg;

    localparam int SM_W  = 8;
    localparam int SM_MW = SM_W - 1;
    localparam logic [SM_MW-1:0] SM_MAG_MAX = '1;

    function automatic logic sm_sign(input logic [SM_W-1:0] v);
        return v[SM_W-1];
    endfunction

    function automatic logic [SM_MW-1:0] sm_mag(input logic [SM_W-1:0] v);
        return v[SM_MW-1:0];
    endfunction

    function automatic logic sm_is_zero(input logic [SM_W-1:0] v);
        return (sm_mag(v) == '0);
    endfunction

    // Packing canonicalises zero: a zero magnitude always carries sign 0,
    // so -0 can never leave a block that packs through this helper.
    function automatic logic [SM_W-1:0] sm_pack(input logic sign, input logic [SM_MW-1:0] mag);
        return {sign & (mag != '0), mag};
    endfunction

endpackage

// File: rtl/sm_mag_addsub.sv
// rtl/sm_mag_addsub.sv - combinational magnitude add/subtract with overflow handling
//
// Purpose: core magnitude datapath of a sign-magnitude add/subtract.
// Ports:
//   i_a_mag, i_b_mag  in  MW   operand magnitudes
//   i_eff_sub         in  1    1 = signs differ, subtract magnitudes
//   i_a_ge            in  1    i_a_mag >= i_b_mag
//   o_mag             out MW   result magnitude (clamped or wrapped on overflow)
//   o_sign_sel_b      out 1    1 = result takes operand b's sign, 0 = operand a's
//   o_ovf             out 1    magnitude sum carried out of MW bits

module sm_mag_addsub #(
    parameter int MW       = 7,
    parameter bit SATURATE = 1'b1
) (
    input  logic [MW-1:0] i_a_mag,
    input  logic [MW-1:0] i_b_mag,
    input  logic          i_eff_sub,
    input  logic          i_a_ge,
    output logic [MW-1:0] o_mag,
    output logic          o_sign_sel_b,
    output logic          o_ovf
);

    logic [MW:0] w_sum;

    assign w_sum = {1'b0, i_a_mag} + {1'b0, i_b_mag};

    always_comb begin
        o_mag        = '0;
        o_sign_sel_b = 1'b0;
        o_ovf        = 1'b0;
        if (!i_eff_sub) begin
            // Only a same-sign add can exceed the magnitude range.
            o_ovf = w_sum[MW];
            if (w_sum[MW] && SATURATE)
                o_mag = '1;
            else
                o_mag = w_sum[MW-1:0];
        end else if (i_a_ge) begin
            o_mag = i_a_mag - i_b_mag;
        end else begin
            o_mag        = i_b_mag - i_a_mag;
            o_sign_sel_b = 1'b1;
        end
    end

endmodule

// File: rtl/sm_sub_pipe.sv
// rtl/sm_sub_pipe.sv - two-stage pipelined sign-magnitude subtractor, out_diff = in_a - in_b
//
// Purpose: streaming subtractor for the convolution error/difference path.
// Stage 1 captures operands with the subtrahend negated; stage 2 holds the
// result and is the output register. Full throughput, at most 2 in flight.
// Ports:
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset
//   in_valid   in  1  operand pair presented
//   in_ready   out 1  pair accepted this cycle
//   in_a       in  W  minuend
//   in_b       in  W  subtrahend
//   out_valid  out 1  result presented
//   out_ready  in  1  downstream accepts result this cycle
//   out_diff   out W  difference
//   out_ovf    out 1  magnitude overflow for this result

module sm_sub_pipe
    import sm_arith_pkg::*;
#(
    parameter int W        = SM_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_diff,
    output logic         out_ovf
);

    localparam int MW = W - 1;

    logic          r_s1_valid;
    logic          r_s1_sa;
    logic          r_s1_sb;
    logic [MW-1:0] r_s1_ma;
    logic [MW-1:0] r_s1_mb;
    logic          r_s1_eff_sub;
    logic          r_s1_a_ge;

    logic          r_s2_valid;
    logic [W-1:0]  r_diff;
    logic          r_ovf;

    logic          w_adv1;
    logic          w_adv2;
    logic [MW-1:0] w_a_mag;
    logic [MW-1:0] w_b_mag;
    logic          w_a_sign;
    logic          w_b_sign_neg;
    logic [MW-1:0] w_mag;
    logic          w_sel_b;
    logic          w_ovf;
    logic          w_sign;

    // Ready depends only on registered state and out_ready.
    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    // A zero magnitude is +0 whatever its sign bit, and negating +0 stays +0.
    assign w_a_mag      = in_a[MW-1:0];
    assign w_b_mag      = in_b[MW-1:0];
    assign w_a_sign     = in_a[W-1] & (w_a_mag != '0);
    assign w_b_sign_neg = ~in_b[W-1] & (w_b_mag != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sa      <= w_a_sign;
                r_s1_sb      <= w_b_sign_neg;
                r_s1_ma      <= w_a_mag;
                r_s1_mb      <= w_b_mag;
                r_s1_eff_sub <= w_a_sign ^ w_b_sign_neg;
                r_s1_a_ge    <= (w_a_mag >= w_b_mag);
            end
        end
    end

    sm_mag_addsub #(
        .MW       (MW),
        .SATURATE (SATURATE)
    ) u_mag_addsub (
        .i_a_mag      (r_s1_ma),
        .i_b_mag      (r_s1_mb),
        .i_eff_sub    (r_s1_eff_sub),
        .i_a_ge       (r_s1_a_ge),
        .o_mag        (w_mag),
        .o_sign_sel_b (w_sel_b),
        .o_ovf        (w_ovf)
    );

    assign w_sign = w_sel_b ? r_s1_sb : r_s1_sa;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_ovf      <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                // Zero results are forced positive.
                r_diff <= {w_sign & (w_mag != '0), w_mag};
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_diff  = r_diff;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_sm_sub_pipe.sv
// tb/tb_sm_sub_pipe.sv - self-checking bench for sm_sub_pipe (saturating and wrapping instances)

module tb_sm_sub_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_ready;

    logic       s_in_ready, s_out_valid, s_out_ovf;
    logic [7:0] s_out_diff;
    logic       w_in_ready, w_out_valid, w_out_ovf;
    logic [7:0] w_out_diff;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sm_sub_pipe #(.W(8), .SATURATE(1'b1)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_diff  (s_out_diff),
        .out_ovf   (s_out_ovf)
    );

    sm_sub_pipe #(.W(8), .SATURATE(1'b0)) u_wrap (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_diff  (w_out_diff),
        .out_ovf   (w_out_ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d_sat;
        logic       o_sat;
        logic [7:0] d_wrap;
        logic       o_wrap;
    } vec_t;

    vec_t tbl[13];

    logic [7:0] bp_a[5];
    logic [7:0] bp_b[5];
    logic [7:0] bp_e[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{8'h05, 8'h03, 8'h02, 1'b0, 8'h02, 1'b0};
        tbl[1]  = '{8'h03, 8'h05, 8'h82, 1'b0, 8'h82, 1'b0};
        tbl[2]  = '{8'h85, 8'h03, 8'h88, 1'b0, 8'h88, 1'b0};
        tbl[3]  = '{8'h85, 8'h83, 8'h82, 1'b0, 8'h82, 1'b0};
        tbl[4]  = '{8'h83, 8'h85, 8'h02, 1'b0, 8'h02, 1'b0};
        tbl[5]  = '{8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{8'h00, 8'h80, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{8'h85, 8'h85, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{8'h00, 8'h05, 8'h85, 1'b0, 8'h85, 1'b0};
        tbl[9]  = '{8'h7F, 8'h81, 8'h7F, 1'b1, 8'h00, 1'b1};
        tbl[10] = '{8'hFF, 8'h01, 8'hFF, 1'b1, 8'h00, 1'b1};
        tbl[11] = '{8'h40, 8'hC3, 8'h7F, 1'b1, 8'h03, 1'b1};
        tbl[12] = '{8'h7F, 8'h7F, 8'h00, 1'b0, 8'h00, 1'b0};

        bp_a = '{8'h10, 8'h20, 8'h81, 8'h05, 8'h30};
        bp_b = '{8'h01, 8'h05, 8'h02, 8'h85, 8'h31};
        bp_e = '{8'h0F, 8'h1B, 8'h83, 8'h0A, 8'h81};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_out_diff", s_out_diff, 0);
        chk("rst_out_ovf", s_out_ovf, 0);
        chk("rst_in_ready", s_in_ready, 1);
        chk("rst_wrap_out_valid", w_out_valid, 0);
        next_cycle();

        // One pair at a time: accepted at the first edge, presented after the second.
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_a     = tbl[i].a;
            in_b     = tbl[i].b;
            #1;
            chk($sformatf("v%0d_in_ready", i), s_in_ready, 1);
            next_cycle();
            in_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_early_valid", i), s_out_valid, 0);
            next_cycle();
            #1;
            chk($sformatf("v%0d_out_valid", i), s_out_valid, 1);
            chk($sformatf("v%0d_diff_sat", i), s_out_diff, tbl[i].d_sat);
            chk($sformatf("v%0d_ovf_sat", i), s_out_ovf, tbl[i].o_sat);
            chk($sformatf("v%0d_diff_wrap", i), w_out_diff, tbl[i].d_wrap);
            chk($sformatf("v%0d_ovf_wrap", i), w_out_ovf, tbl[i].o_wrap);
        end
        next_cycle();
        #1;
        chk("drain_out_valid", s_out_valid, 0);

        // Backpressure: 5 back-to-back pairs, out_ready low in cycles 3..6.
        begin
            int         p;
            int         q;
            logic       held_v;
            logic [7:0] held_d;
            p      = 0;
            q      = 0;
            held_v = 1'b0;
            held_d = 8'h00;
            for (int c = 0; c < 30; c++) begin
                in_valid  = (p < 5);
                in_a      = bp_a[(p < 5) ? p : 0];
                in_b      = bp_b[(p < 5) ? p : 0];
                out_ready = !(c >= 3 && c <= 6);
                #1;
                chk($sformatf("bp_c%0d_in_ready", c), s_in_ready,
                    ((p - q) == 2 && !out_ready) ? 0 : 1);
                if (held_v)
                    chk($sformatf("bp_c%0d_stall_hold", c), s_out_diff, held_d);
                if (s_out_valid && out_ready) begin
                    if (q < 5)
                        chk($sformatf("bp_order%0d", q), s_out_diff, bp_e[q]);
                    q++;
                end
                held_v = s_out_valid && !out_ready;
                held_d = s_out_diff;
                if (in_valid && s_in_ready)
                    p++;
                next_cycle();
            end
            chk("bp_accepted", p, 5);
            chk("bp_delivered", q, 5);
        end

        // Reset with two results in flight.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_a      = 8'h05;
        in_b      = 8'h03;
        next_cycle();
        in_a = 8'h20;
        in_b = 8'h05;
        #1;
        chk("mf_second_ready", s_in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        chk("mf_pre_rst_valid", s_out_valid, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("mf_out_valid", s_out_valid, 0);
        chk("mf_out_diff", s_out_diff, 0);
        chk("mf_out_ovf", s_out_ovf, 0);
        chk("mf_in_ready", s_in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("mf_no_ghost%0d", k), s_out_valid, 0);
            next_cycle();
        end
        in_valid = 1'b1;
        in_a     = 8'h10;
        in_b     = 8'h01;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        #1;
        chk("mf_next_valid", s_out_valid, 1);
        chk("mf_next_diff", s_out_diff, 8'h0F);
        chk("mf_next_ovf", s_out_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
